// File: rtl/kem_sample_ntt_rej_pkg.sv
// Shared types and constants for the ML-KEM SampleNTT rejection sampler.
package kem_sample_ntt_rej_pkg;

    localparam int ML_KEM_N  = 256;
    localparam int ML_KEM_Q  = 3329;
    localparam int LANE_W    = 64;
    localparam int BUF_BYTES = 10;

    typedef logic [11:0]                coef_t;
    typedef coef_t [ML_KEM_N-1:0]       poly_t;
    typedef logic [LANE_W-1:0]          keccak_lane_t;
    typedef logic [BUF_BYTES-1:0][7:0]  rej_buf_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic bit is_below_q(input logic [11:0] d);
        return (d < 12'(ML_KEM_Q));
    endfunction

endpackage

// File: rtl/kem_sample_ntt_rej_parse.sv
// Splits one 3-byte group into two 12-bit candidates and flags those below q.
module kem_rej_parse
    import kem_sample_ntt_rej_pkg::*;
(
    input  logic [7:0] b0_i,
    input  logic [7:0] b1_i,
    input  logic [7:0] b2_i,
    output coef_t      d1_o,
    output coef_t      d2_o,
    output logic       acc1_o,
    output logic       acc2_o
);

    assign d1_o   = {b1_i[3:0], b0_i};
    assign d2_o   = {b2_i, b1_i[7:4]};
    assign acc1_o = is_below_q(d1_o);
    assign acc2_o = is_below_q(d2_o);

endmodule

// File: rtl/kem_sample_ntt_rej.sv
// SampleNTT rejection sampler: fills one poly_t from a SHAKE128 lane stream.
// Optional rejected-candidate counter enabled by defining SAMPLE_REJ_STATS_EN.
module kem_sample_ntt_rej
    import kem_sample_ntt_rej_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  keccak_lane_t lane_i,
    input  logic         lane_valid_i,
    output logic         lane_ready_o,
    output poly_t        poly_o,
    output logic [8:0]   coef_cnt_o,
    output logic         busy_o,
    output logic         done_o
`ifdef SAMPLE_REJ_STATS_EN
    ,
    output logic [15:0]  rej_cnt_o
`endif
);

    state_t     state_q, state_d;
    rej_buf_t   buf_q, buf_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] cnt_mid;
    poly_t      poly_q, poly_d;
    coef_t      d1, d2;
    logic       acc1, acc2;
    logic       xfer;

`ifdef SAMPLE_REJ_STATS_EN
    logic [15:0] rej_q, rej_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rej_cnt_o = rej_q;
`endif

    kem_rej_parse u_parse (
        .b0_i   (buf_q[0]),
        .b1_i   (buf_q[1]),
        .b2_i   (buf_q[2]),
        .d1_o   (d1),
        .d2_o   (d2),
        .acc1_o (acc1),
        .acc2_o (acc2)
    );

    assign lane_ready_o = (state_q == ST_FILL) && (byte_cnt_q < 4'd3);
    assign xfer         = lane_valid_i && lane_ready_o;
    assign poly_o       = poly_q;
    assign coef_cnt_o   = cnt_q;
    assign busy_o       = (state_q == ST_FILL);
    assign done_o       = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        cnt_mid    = cnt_q;
        poly_d     = poly_q;
`ifdef SAMPLE_REJ_STATS_EN
        rej_d      = rej_q;
`endif
        if (start_i) begin
            state_d    = ST_FILL;
            buf_d      = '0;
            byte_cnt_d = '0;
            cnt_d      = '0;
`ifdef SAMPLE_REJ_STATS_EN
            rej_d      = '0;
`endif
        end else if (state_q == ST_FILL) begin
            if (xfer) begin
                // New lane lands right behind the leftover bytes (at most 2 of them).
                for (int k = 0; k < 8; k++) begin
                    buf_d[byte_cnt_q + 4'(k)] = lane_i[8*k +: 8];
                end
                byte_cnt_d = byte_cnt_q + 4'd8;
            end else if (byte_cnt_q >= 4'd3) begin
                buf_d      = buf_q >> 24;
                byte_cnt_d = byte_cnt_q - 4'd3;
                if (acc1) begin
                    poly_d[cnt_q[7:0]] = d1;
                    cnt_mid            = cnt_q + 9'd1;
                end
`ifdef SAMPLE_REJ_STATS_EN
                else begin
                    rej_d = sat_inc(rej_d);
                end
`endif
                cnt_d = cnt_mid;
                // d2 is only examined while there is still a free slot.
                if (!cnt_mid[8]) begin
                    if (acc2) begin
                        poly_d[cnt_mid[7:0]] = d2;
                        cnt_d                = cnt_mid + 9'd1;
                    end
`ifdef SAMPLE_REJ_STATS_EN
                    else begin
                        rej_d = sat_inc(rej_d);
                    end
`endif
                end
                if (cnt_d[8]) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            byte_cnt_q <= '0;
            cnt_q      <= '0;
            poly_q     <= '0;
`ifdef SAMPLE_REJ_STATS_EN
            rej_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= cnt_d;
            poly_q     <= poly_d;
`ifdef SAMPLE_REJ_STATS_EN
            rej_q      <= rej_d;
`endif
        end
    end

endmodule

// File: tb/tb_kem_sample_ntt_rej.sv
// Self-checking bench for kem_sample_ntt_rej against a byte-stream SampleNTT model.
module tb_kem_sample_ntt_rej;
    import kem_sample_ntt_rej_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    keccak_lane_t lane_i = '0;
    logic         lane_valid_i = 1'b0;
    logic         lane_ready_o;
    poly_t        poly_o;
    logic [8:0]   coef_cnt_o;
    logic         busy_o;
    logic         done_o;
`ifdef SAMPLE_REJ_STATS_EN
    logic [15:0]  rej_cnt_o;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  strm[$];
    logic [11:0] exp_poly[256];
    int          exp_groups, exp_rej, exp_lanes;

    kem_sample_ntt_rej dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .lane_i       (lane_i),
        .lane_valid_i (lane_valid_i),
        .lane_ready_o (lane_ready_o),
        .poly_o       (poly_o),
        .coef_cnt_o   (coef_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef SAMPLE_REJ_STATS_EN
        ,
        .rej_cnt_o    (rej_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_poly(input string tag);
        int bad = -1;
        for (int n = 0; n < 256; n++)
            if (bad < 0 && poly_o[n] !== exp_poly[n]) bad = n;
        n_checks++;
        assert (bad < 0) else begin
            n_err++;
            $error("FAIL %s poly[%0d] observed=%0d expected=%0d", tag, bad, poly_o[bad], exp_poly[bad]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_random(input int n);
        strm.delete();
        repeat (n) strm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic push_group(input logic [11:0] a, input logic [11:0] b);
        strm.push_back(a[7:0]);
        strm.push_back({b[3:0], a[11:8]});
        strm.push_back(b[11:4]);
    endtask

    // Software SampleNTT over the byte stream.
    task automatic model();
        int cnt = 0;
        int g = 0;
        int a, b;
        exp_rej = 0;
        for (int n = 0; n < 256; n++) exp_poly[n] = '0;
        while (cnt < 256 && 3*g + 2 < strm.size()) begin
            a = int'(strm[3*g]) + 256 * (int'(strm[3*g+1]) % 16);
            b = int'(strm[3*g+1]) / 16 + 16 * int'(strm[3*g+2]);
            g++;
            if (a < 3329) begin exp_poly[cnt] = 12'(a); cnt++; end
            else exp_rej++;
            if (cnt < 256) begin
                if (b < 3329) begin exp_poly[cnt] = 12'(b); cnt++; end
                else exp_rej++;
            end
        end
        exp_groups = g;
        exp_lanes  = (3*g + 7) / 8;
    endtask

    function automatic keccak_lane_t lane_of(input int li);
        keccak_lane_t v = '0;
        for (int k = 0; k < 8; k++)
            if (8*li + k < strm.size()) v[8*k +: 8] = strm[8*li + k];
        return v;
    endfunction

    task automatic pulse_start();
        lane_valid_i = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic run_stream(input bit gaps, input int stop_cnt, output int lanes_taken);
        int  li = 0;
        int  ncyc = 0;
        bit  xfer;
        bit  seen = 0;
        logic prev_done = done_o;
        lane_i = lane_of(0);
        lane_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        while (ncyc < 3000) begin
            xfer = lane_valid_i && lane_ready_o;
            cyc();
            ncyc++;
            if (xfer) li++;
            if (stop_cnt < 256) begin
                if (int'(coef_cnt_o) >= stop_cnt) break;
            end else if (coef_cnt_o == 9'd256) begin
                chk("done_with_256th", done_o, 1);
                chk("done_low_before", prev_done, 0);
                seen = 1;
                break;
            end
            prev_done = done_o;
            if (!gaps) lane_valid_i = 1'b1;
            else if (xfer || !lane_valid_i) lane_valid_i = ($urandom_range(0, 2) != 0);
            lane_i = lane_of(li);
        end
        if (stop_cnt >= 256 && !seen) chk("run_timeout", coef_cnt_o, 256);
        lanes_taken = li;
    endtask

    task automatic full_check(input string tag, input bit gaps);
        int lanes;
        int extra = 0;
        model();
        pulse_start();
        chk({tag, "_cnt_start"}, coef_cnt_o, 0);
        chk({tag, "_busy_start"}, busy_o, 1);
        chk({tag, "_done_start"}, done_o, 0);
        run_stream(gaps, 256, lanes);
        chk({tag, "_lanes"}, lanes, exp_lanes);
        chk_poly({tag, "_poly"});
`ifdef SAMPLE_REJ_STATS_EN
        chk({tag, "_rej"}, rej_cnt_o, exp_rej);
`endif
        lane_valid_i = 1'b1;
        repeat (4) begin
            if (lane_ready_o) extra++;
            cyc();
        end
        lane_valid_i = 1'b0;
        chk({tag, "_no_more_lanes"}, extra, 0);
        chk({tag, "_done_held"}, done_o, 1);
        chk({tag, "_busy_end"}, busy_o, 0);
        chk({tag, "_cnt_end"}, coef_cnt_o, 256);
    endtask

    initial begin
        int lanes;
        int bcm;
        int parses;
        bit xf;

        // Reset values
        repeat (2) cyc();
        chk("rst_ready", lane_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", coef_cnt_o, 0);
        chk("rst_poly_or", |poly_o, 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_ready", lane_ready_o, 0);

        // Largest accepted value in both slots
        pulse_start();
        chk("bnd_ready", lane_ready_o, 1);
        chk("bnd_busy", busy_o, 1);
        lane_i = 64'h0000_0000_00D0_0D00;
        lane_valid_i = 1'b1;
        cyc();
        lane_valid_i = 1'b0;
        chk("bnd_ready_after_xfer", lane_ready_o, 0);
        chk("bnd_cnt_xfer_cycle", coef_cnt_o, 0);
        cyc();
        chk("bnd_cnt", coef_cnt_o, 2);
        chk("bnd_poly0", poly_o[0], 3328);
        chk("bnd_poly1", poly_o[1], 3328);
        cyc();
        chk("bnd_cnt_zeros", coef_cnt_o, 4);
        chk("bnd_poly2", poly_o[2], 0);

        // Candidate equal to q is rejected
        pulse_start();
        chk("rq_cnt_flush", coef_cnt_o, 0);
        lane_i = 64'hFFFF_FFFF_FF00_0D01;
        lane_valid_i = 1'b1;
        cyc();
        lane_valid_i = 1'b0;
        cyc();
        chk("rq_cnt", coef_cnt_o, 1);
        chk("rq_poly0", poly_o[0], 0);
`ifdef SAMPLE_REJ_STATS_EN
        chk("rq_rej", rej_cnt_o, 1);
`endif
        cyc();
        chk("rq_cnt_ff", coef_cnt_o, 1);
`ifdef SAMPLE_REJ_STATS_EN
        chk("rq_rej_ff", rej_cnt_o, 3);
`endif

        // All-ones lanes: everything rejected, ready follows buffered byte count
        pulse_start();
        lane_i = '1;
        lane_valid_i = 1'b1;
        bcm = 0;
        parses = 0;
        for (int c = 0; c < 16; c++) begin
            chk("ones_ready", lane_ready_o, (bcm < 3));
            xf = (bcm < 3);
            cyc();
            if (xf) bcm += 8;
            else if (bcm >= 3) begin bcm -= 3; parses++; end
        end
        lane_valid_i = 1'b0;
        chk("ones_cnt", coef_cnt_o, 0);
`ifdef SAMPLE_REJ_STATS_EN
        chk("ones_rej", rej_cnt_o, 2 * parses);
`endif

        // Random stream, gap-free then with backpressure
        gen_random(1200);
        full_check("rand", 1'b0);
        full_check("gaps", 1'b1);

        // 256th coefficient is a d1 whose d2 is valid
        strm.delete();
        for (int i = 0; i < 127; i++)
            push_group(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)));
        push_group(12'($urandom_range(0, 3328)), 12'($urandom_range(3329, 4095)));
        push_group(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)));
        repeat (30) strm.push_back(8'($urandom_range(0, 255)));
        full_check("odd", 1'b0);
        chk("odd_groups", exp_groups, 129);

        // Restart mid-run; leftover bytes must not leak into the new run
        gen_random(1200);
        pulse_start();
        run_stream(1'b0, 100, lanes);
        chk("restart_reached", (coef_cnt_o >= 9'd100), 1);
        gen_random(1200);
        full_check("restart", 1'b0);

        // Reset mid-run
        gen_random(1200);
        pulse_start();
        run_stream(1'b0, 50, lanes);
        rst_n = 1'b0;
        cyc();
        chk("mrst_ready", lane_ready_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_cnt", coef_cnt_o, 0);
        chk("mrst_poly_or", |poly_o, 0);
`ifdef SAMPLE_REJ_STATS_EN
        chk("mrst_rej", rej_cnt_o, 0);
`endif
        lane_valid_i = 1'b0;
        rst_n = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
